// File: rtl/ping_pong_if.sv
// Handshake and buffer-control bundle between the ping-pong controller and
// its producer, consumer and the two-bank buffer.
interface ping_pong_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_req;
    logic                  rd_en;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  out_valid;
    logic [1:0]            bank_full;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, in_valid, rd_req,
        output in_ready, wr_en, wr_bank, wr_addr,
        output rd_en, rd_bank, rd_addr, out_valid, bank_full, busy, done
    );

    modport slave (
        output start, in_valid, rd_req,
        input  in_ready, wr_en, wr_bank, wr_addr,
        input  rd_en, rd_bank, rd_addr, out_valid, bank_full, busy, done
    );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Double-buffer (ping-pong) controller: the producer fills one bank while the
// consumer drains the other, for NUM_TILES tiles of DEPTH words per job.
module ping_pong_ctrl #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_TILES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ping_pong_if.master bus
);
    localparam int                    TILE_W    = $clog2(NUM_TILES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TILE_W-1:0]     TILES     = TILE_W'(NUM_TILES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wcnt, rcnt;
    logic [TILE_W-1:0]     wr_tiles, rd_tiles;
    logic                  wb, rb;
    logic [1:0]            bank_full;
    logic                  vld_p1;

    logic                  run;
    logic                  in_ready_c;
    logic                  wr_hs, rd_hs;
    logic                  wr_last, rd_last;
    logic [1:0]            full_set, full_clr;

    assign run = (state == RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (rd_tiles == TILES) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bank flags only change at the edge, so a bank drained this cycle is
    // not offered to the producer until the next one.
    always_comb begin
        in_ready_c = run && !bank_full[wb] && (wr_tiles < TILES);
        wr_hs      = bus.in_valid && in_ready_c;
        rd_hs      = run && bus.rd_req && bank_full[rb];
        wr_last    = wr_hs && (wcnt == LAST_ADDR);
        rd_last    = rd_hs && (rcnt == LAST_ADDR);
        full_set   = {wb, ~wb} & {2{wr_last}};
        full_clr   = {rb, ~rb} & {2{rd_last}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            rcnt      <= '0;
            wr_tiles  <= '0;
            rd_tiles  <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            bank_full <= 2'b00;
        end else if (state == IDLE && bus.start) begin
            wcnt      <= '0;
            rcnt      <= '0;
            wr_tiles  <= '0;
            rd_tiles  <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            bank_full <= 2'b00;
        end else begin
            if (wr_hs) begin
                wcnt <= wr_last ? '0 : wcnt + 1'b1;
                if (wr_last) begin
                    wb       <= ~wb;
                    wr_tiles <= wr_tiles + 1'b1;
                end
            end
            if (rd_hs) begin
                rcnt <= rd_last ? '0 : rcnt + 1'b1;
                if (rd_last) begin
                    rb       <= ~rb;
                    rd_tiles <= rd_tiles + 1'b1;
                end
            end
            bank_full <= (bank_full | full_set) & ~full_clr;
        end
    end

    // p0 -> p1: buffer read data appears one cycle after the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= rd_hs;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.wr_en     = wr_hs;
    assign bus.wr_bank   = run & wb;
    assign bus.wr_addr   = run ? wcnt : '0;
    assign bus.rd_en     = rd_hs;
    assign bus.rd_bank   = run & rb;
    assign bus.rd_addr   = run ? rcnt : '0;
    assign bus.out_valid = vld_p1;
    assign bus.bank_full = bank_full;
    assign bus.busy      = run;
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Self-checking bench for ping_pong_ctrl against a tile-occupancy reference model.
module tb_ping_pong_ctrl;
    localparam int DEPTH = 8;
    localparam int NT    = 4;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ping_pong_if #(.ADDR_WIDTH(AW)) bus();

    ping_pong_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_TILES(NT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 running, 2 done; words written/read so far.
    int phase = 0;
    int nw = 0;
    int nr = 0;
    bit prev_rd = 1'b0;
    int dw, dr, nd;
    int checks = 0;
    int failures = 0;

    // {busy, done, in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, bank_full, out_valid}
    function automatic logic [15:0] exp_vec();
        int wt, rt;
        logic run, ir, we, re, wbk, rbk;
        logic [1:0] bf;
        logic [2:0] wa, ra;
        wt  = nw / DEPTH;
        rt  = nr / DEPTH;
        run = (phase == 1);
        ir  = run && (wt < NT) && (wt - rt < 2);
        we  = ir && bus.in_valid;
        re  = run && bus.rd_req && (wt > rt);
        bf  = 2'b00;
        for (int t = rt; t < wt; t++) bf[t % 2] = 1'b1;
        wa  = run ? 3'(nw % DEPTH) : 3'd0;
        ra  = run ? 3'(nr % DEPTH) : 3'd0;
        wbk = run && (wt % 2 == 1);
        rbk = run && (rt % 2 == 1);
        return {run, 1'(phase == 2), ir, we, wbk, wa, re, rbk, ra, bf, prev_rd};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.busy, bus.done, bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_addr,
                bus.rd_en, bus.rd_bank, bus.rd_addr, bus.bank_full, bus.out_valid};
    endfunction

    task automatic drive(input bit st, input bit iv, input bit rr);
        bus.start    = st;
        bus.in_valid = iv;
        bus.rd_req   = rr;
        @(negedge clk);
        if (bus.wr_en) dw++;
        if (bus.rd_en) dr++;
        if (bus.done)  nd++;
    endtask

    task automatic tick();
        logic [15:0] e;
        bit end_run, st;
        e       = exp_vec();
        end_run = (phase == 1) && (nr / DEPTH == NT);
        st      = bus.start;
        @(posedge clk);
        prev_rd = e[7];
        if (phase == 1) begin
            nw += int'(e[12]);
            nr += int'(e[7]);
        end
        if (end_run) phase = 2;
        else if (phase == 2) phase = 0;
        else if (phase == 0 && st) begin
            phase = 1;
            nw = 0;
            nr = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.in_valid = 0; bus.rd_req = 0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec() !== 16'h0000) begin
            failures++;
            $display("FAIL reset_hold act=%h exp=%h", dut_vec(), 16'h0000);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1, 1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_gating act=%h exp=%h", dut_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_fill();
        int k;
        dw = 0; dr = 0; nd = 0;
        for (k = 0; k < 20; k++) begin
            drive(k == 0, 1, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL fill cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        drive(0, 1, 0);
        checks++;
        if (bus.bank_full !== 2'b11 || bus.in_ready !== 1'b0 || dw != 16) begin
            failures++;
            $display("FAIL fill_full act=%b/%b/%0d exp=11/0/16", bus.bank_full, bus.in_ready, dw);
        end
        tick();
        for (k = 0; k < 400 && phase != 0; k++) begin
            drive(0, 1'($urandom_range(0, 1)), 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL drain cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (phase != 0 || dw != 32 || dr != 32 || nd != 1) begin
            failures++;
            $display("FAIL fill_totals act=%0d/%0d/%0d exp=32/32/1", dw, dr, nd);
        end
    endtask

    task automatic test_streaming();
        int k;
        dw = 0; dr = 0; nd = 0;
        for (k = 0; k < 400 && !(k > 0 && phase == 0); k++) begin
            drive(k == 0, 1, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stream cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (phase != 0 || dw != 32 || dr != 32 || nd != 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL stream_totals act=%0d/%0d/%0d exp=32/32/1", dw, dr, nd);
        end
    endtask

    task automatic test_simultaneous();
        int  len [3] = '{8, 7, 7};
        bit  ivs [3] = '{1, 1, 0};
        bit  rrs [3] = '{0, 0, 1};
        int  k;
        dw = 0; dr = 0; nd = 0;
        drive(1, 0, 0);
        tick();
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                drive(0, ivs[s], rrs[s]);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL simul_setup seg=%0d act=%h exp=%h", s, dut_vec(), exp_vec());
                end
                tick();
            end
        end
        drive(0, 1, 1);
        checks++;
        if ({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.rd_en, bus.rd_bank, bus.rd_addr, bus.bank_full}
            !== {1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 3'd7, 2'b01}) begin
            failures++;
            $display("FAIL simul_edge act=%b%b%0d %b%b%0d %b exp=117 107 01", bus.wr_en, bus.wr_bank,
                     bus.wr_addr, bus.rd_en, bus.rd_bank, bus.rd_addr, bus.bank_full);
        end
        tick();
        drive(0, 0, 0);
        checks++;
        if (bus.bank_full !== 2'b10 || bus.wr_bank !== 1'b0 || bus.rd_bank !== 1'b1) begin
            failures++;
            $display("FAIL simul_after act=%b wb=%b rb=%b exp=10 wb=0 rb=1", bus.bank_full, bus.wr_bank, bus.rd_bank);
        end
        tick();
        for (k = 0; k < 400 && phase != 0; k++) begin
            drive(0, 1, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL simul_finish cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (phase != 0 || dw != 32 || dr != 32 || nd != 1) begin
            failures++;
            $display("FAIL simul_totals act=%0d/%0d/%0d exp=32/32/1", dw, dr, nd);
        end
    endtask

    task automatic test_stall();
        int k;
        dw = 0; dr = 0; nd = 0;
        for (k = 0; k < 600 && !(k > 0 && phase == 0); k++) begin
            drive(k == 0, 1'($urandom_range(0, 1)), 1'(k % 2));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stall cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (phase != 0 || dw != 32 || dr != 32 || nd != 1) begin
            failures++;
            $display("FAIL stall_totals act=%0d/%0d/%0d exp=32/32/1", dw, dr, nd);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        dw = 0; dr = 0; nd = 0;
        for (k = 0; k < 12; k++) begin
            drive(k == 0, k > 0, k > 8);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL mid_setup cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (dw != 11 || dr != 3) begin
            failures++;
            $display("FAIL mid_progress act=%0d/%0d exp=11/3", dw, dr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 16'h0000) begin
            failures++;
            $display("FAIL mid_async_reset act=%h exp=%h", dut_vec(), 16'h0000);
        end
        phase = 0; nw = 0; nr = 0; prev_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dw = 0; dr = 0; nd = 0;
        drive(1, 0, 0);
        tick();
        drive(0, 1, 0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd0 || bus.wr_bank !== 1'b0) begin
            failures++;
            $display("FAIL mid_restart act=%b/%0d/%b exp=1/0/0", bus.wr_en, bus.wr_addr, bus.wr_bank);
        end
        tick();
        for (k = 0; k < 400 && phase != 0; k++) begin
            drive(0, 1, 1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL mid_finish cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (phase != 0 || dw != 32 || dr != 32 || nd != 1) begin
            failures++;
            $display("FAIL mid_totals act=%0d/%0d/%0d exp=32/32/1", dw, dr, nd);
        end
    endtask

    task automatic test_start_while_run();
        int k;
        dw = 0; dr = 0; nd = 0;
        for (k = 0; k < 600 && !(k > 0 && phase == 0); k++) begin
            drive(k == 0 || k == 6 || k == 20, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rerun cyc=%0d act=%h exp=%h", k, dut_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (phase != 0 || dw != 32 || dr != 32 || nd != 1) begin
            failures++;
            $display("FAIL rerun_totals act=%0d/%0d/%0d exp=32/32/1", dw, dr, nd);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_simultaneous();
        test_stall();
        test_reset_mid();
        test_start_while_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ping_pong_ctrl.md
PING_PONG_CTRL -- requirements
Module: ping_pong_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, words per bank (one tile).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), bank address width.
REQ-003 SHALL have parameter NUM_TILES, default 16, tiles per job (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  job start pulse.
REQ-007 SHALL have port in_valid  input  1  producer word valid.
REQ-008 SHALL have port in_ready  output  1  controller can accept a word.
REQ-009 SHALL have port wr_en  output  1  buffer write strobe.
REQ-010 SHALL have port wr_bank  output  1  bank being written.
REQ-011 SHALL have port wr_addr  output  ADDR_WIDTH  write address within bank.
REQ-012 SHALL have port rd_req  input  1  consumer requests a word.
REQ-013 SHALL have port rd_en  output  1  buffer read strobe.
REQ-014 SHALL have port rd_bank  output  1  bank being read.
REQ-015 SHALL have port rd_addr  output  ADDR_WIDTH  read address within bank.
REQ-016 SHALL have port out_valid  output  1  read data valid at buffer output.
REQ-017 SHALL have port bank_full  output  2  per-bank full flag.
REQ-018 SHALL have port busy  output  1  high in RUN.
REQ-019 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-020 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when rd_tiles reaches NUM_TILES; DONE -> IDLE unconditionally after one cycle.
REQ-021 SHALL, on IDLE->RUN, clear wcnt, rcnt, wr_tiles, rd_tiles, bank_full, and set wb=rb=0.
REQ-022 SHALL ignore start outside IDLE.
REQ-023 SHALL drive in_ready = RUN && !bank_full[wb] && wr_tiles<NUM_TILES, combinationally.
REQ-024 SHALL assert wr_en = in_valid && in_ready in the same cycle, with wr_bank=wb, wr_addr=wcnt.
REQ-025 SHALL increment wcnt per write; at wcnt=DEPTH-1 wrap to 0, set bank_full[wb], toggle wb, increment wr_tiles.
REQ-026 SHALL drive rd_en = RUN && rd_req && bank_full[rb], combinationally, with rd_bank=rb, rd_addr=rcnt.
REQ-027 SHALL increment rcnt per read; at rcnt=DEPTH-1 wrap to 0, clear bank_full[rb], toggle rb, increment rd_tiles.
REQ-028 SHALL register out_valid = rd_en delayed exactly one cycle (1-cycle buffer read latency).
REQ-029 SHALL apply bank_full updates at the clock edge only; a bank freed in cycle N is writable from cycle N+1 (no same-cycle bypass).
REQ-030 SHALL permit a tile-completing write and a tile-completing read in the same cycle (necessarily different banks); both updates take effect.
REQ-031 SHALL hold wcnt/rcnt/wb/rb unchanged when no handshake occurs (stalls on either side lossless).
REQ-032 SHALL, when both banks full, deassert in_ready until a bank drains; when both empty, suppress rd_en regardless of rd_req.
REQ-033 SHALL pulse done for exactly one cycle in DONE, with busy low in IDLE and DONE.
REQ-034 SHALL size wr_tiles/rd_tiles as $clog2(NUM_TILES+1) bits; no overflow since writes stop at NUM_TILES.

Reset
REQ-035 SHALL, on rst_n low at any time, asynchronously force IDLE, all counters 0, wb=rb=0, bank_full=2'b00, out_valid=0, done=0, busy=0.
REQ-036 SHALL, while not in RUN, hold in_ready, wr_en, rd_en at 0; wr_bank, rd_bank, wr_addr, rd_addr then 0.
REQ-037 SHALL, on reset mid-job, discard all progress; a subsequent start begins a fresh job.

Verification (DEPTH=8, NUM_TILES=4)
REQ-038 Fill: start, in_valid held, rd_req=0 -> 16 writes (addr 0..7 bank0, 0..7 bank1), bank_full=2'b11, in_ready=0 from cycle 17.
REQ-039 Streaming: in_valid=rd_req=1 continuously -> 32 writes, 32 reads in bank order 0,1,0,1, out_valid trails rd_en by 1, one done pulse, then IDLE.
REQ-040 Simultaneous: write completes bank1 while read completes bank0 same cycle -> bank_full goes 2'b01 -> 2'b10, wb=0, rb=1.
REQ-041 Stall: rd_req toggled every cycle, in_valid random -> no address skipped or repeated; totals 32/32.
REQ-042 Reset mid-job: rst_n low after 11 writes and 3 reads -> all outputs reset values immediately; new start gives wr_addr=0, wr_bank=0.
REQ-043 Start while RUN: extra start pulse -> counters unaffected, job completes normally.
